ovr_loader: RTL and testbench
=============================

OVR_LOADER -- requirements
Module: ovr_loader

Interface
REQ-001 SHALL have parameter OVR_INDEX, default 8'd2: the ioctl_index value that selects overlay download.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: word FIFO depth, power of two, at least 2.
REQ-003 SHALL have clk_sys  in  1  system clock; all logic runs on its rising edge.
REQ-004 SHALL have reset_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have ioctl_download  in  1  download in progress.
REQ-006 SHALL have ioctl_index  in  8  download target index.
REQ-007 SHALL have ioctl_wr  in  1  byte strobe, one cycle.
REQ-008 SHALL have ioctl_addr  in  25  byte address.
REQ-009 SHALL have ioctl_dout  in  8  byte data.
REQ-010 SHALL have ioctl_wait  out  1  backpressure to the HPS.
REQ-011 SHALL have sdram_sz  in  16  SDRAM size; sdram_sz[2:0] != 0 means SDRAM is present.
REQ-012 SHALL have mem_we  out  1  write request, one-cycle pulse.
REQ-013 SHALL have mem_addr  out  25  byte address, bit0 = 0.
REQ-014 SHALL have mem_din  out  16  write word.
REQ-015 SHALL have mem_ready  in  1  controller idle; a write is complete when mem_ready is high in a cycle after mem_we.
REQ-016 SHALL have ovr_valid  out  1  overlay image is loaded and usable by the picture reader.
REQ-017 SHALL have ovr_words  out  24  number of words written in the last overlay download.
REQ-018 SHALL have ovr_sum  out  16  checksum (see Configuration).

Function
REQ-019 Active download SHALL mean ioctl_download=1 and ioctl_index==OVR_INDEX; all other strobes SHALL be ignored.
REQ-020 Even-address byte SHALL be held as pending low byte with its address.
REQ-021 Odd-address byte SHALL push {byte, pending_low} at address {ioctl_addr[24:1],0} when a pending low byte exists with the same ioctl_addr[24:1].
REQ-022 Odd-address byte with no matching pending low byte SHALL push {byte, 8'h00}, discarding any mismatched pending byte.
REQ-023 Even byte arriving while a low byte is pending SHALL push {8'h00, old_low} at the old address and make the new byte pending; at most one push per cycle.
REQ-024 Falling edge of active download with a low byte pending SHALL push {8'h00, low}.
REQ-025 FIFO SHALL hold {addr, data}; ioctl_wait SHALL be 1 when occupancy >= FIFO_DEPTH-1, registered.
REQ-026 A push to a full FIFO SHALL be dropped, and an internal overflow flag SHALL be set.
REQ-027 Write FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-028 IDLE -> ISSUE SHALL occur when the FIFO is non-empty; ISSUE SHALL drive mem_we=1 for one cycle with the FIFO head and pop the FIFO.
REQ-029 ISSUE -> WAIT SHALL be unconditional.
REQ-030 WAIT -> IDLE SHALL occur on mem_ready=1.
REQ-031 Write latency SHALL be: push at cycle N, mem_we at N+2 at the earliest.
REQ-032 mem_addr and mem_din SHALL be stable from ISSUE until WAIT exits.
REQ-033 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-034 Rising edge of active download SHALL clear ovr_valid, ovr_words, ovr_sum, the pending byte and the overflow flag in the same cycle.
REQ-035 ovr_words SHALL increment per ISSUE, saturating at 24'hFFFFFF.
REQ-036 Finalize SHALL occur at the first cycle with download inactive, FIFO empty, FSM in IDLE and no pending byte.
REQ-037 At finalize, ovr_valid SHALL be set to 1 if SDRAM is present, ovr_words != 0 and overflow == 0; otherwise ovr_valid SHALL remain 0.
REQ-038 With SDRAM absent, the block SHALL NOT push, mem_we SHALL stay 0, ioctl_wait SHALL stay 0 and ovr_valid SHALL stay 0.
REQ-039 ovr_valid SHALL persist across downloads of other indexes.

Reset
REQ-040 reset_n=0 SHALL asynchronously force: ioctl_wait, mem_we, ovr_valid = 0; mem_addr, mem_din, ovr_words, ovr_sum = 0; FIFO empty; FSM in IDLE; no pending byte.
REQ-041 Reset asserted mid-write SHALL abandon the transfer without a further mem_we.
REQ-042 After reset release, the next active-download rising edge SHALL start a clean load.

Configuration
REQ-043 With macro OVR_LOADER_CHECKSUM_EN defined, ovr_sum SHALL be the 16-bit wrapping sum of every mem_din issued since the last download start.
REQ-044 Without OVR_LOADER_CHECKSUM_EN, ovr_sum SHALL be constant 16'h0000 and no adder SHALL be synthesized.

Verification
REQ-045 Scenario: index 2, sdram_sz=1, bytes 11,22,33,44 at addresses 0..3, mem_ready=1 -> writes (0,16'h2211) and (2,16'h4433); ovr_words=2; ovr_valid=1; ovr_sum=16'h6644 with the macro, 0 without.
REQ-046 Scenario: 3 bytes AA,BB,CC at addresses 0..2, then download drops -> writes 16'hBBAA@0 and 16'h00CC@2; ovr_valid=1.
REQ-047 Scenario: mem_ready held 0 for 40 cycles while bytes stream -> ioctl_wait=1 at occupancy 3; no dropped words; all words written in order after mem_ready=1.
REQ-048 Scenario: sdram_sz=0, 100 bytes -> mem_we never asserted; ovr_valid=0; ioctl_wait=0.
REQ-049 Scenario: index 1 download after a valid overlay -> no writes; ovr_valid stays 1.
REQ-050 Scenario: reset_n pulsed low during WAIT -> all outputs 0 asynchronously; no mem_we after release.

Source files
------------

// File: rtl/ovr_loader.sv
// ovr_loader: packs overlay download bytes into 16-bit words and writes them to SDRAM through a small FIFO.
// Optional feature: define OVR_LOADER_CHECKSUM_EN to produce a running 16-bit sum of issued words on ovr_sum.
module ovr_loader #(
  parameter logic [7:0] OVR_INDEX  = 8'd2,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic [15:0] sdram_sz,
  output logic        mem_we,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic        mem_ready,
  output logic        ovr_valid,
  output logic [23:0] ovr_words,
  output logic [15:0] ovr_sum
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEP = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] THR = (AW+1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        r_st;
  logic          r_act_d, r_pend, r_load, r_ovf, r_wait, r_we, r_valid;
  logic [7:0]    r_plow;
  logic [23:0]   r_paddr, r_words;
  logic [24:0]   r_maddr;
  logic [15:0]   r_mdin;
  logic [23:0]   r_fa [FIFO_DEPTH];
  logic [15:0]   r_fd [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;

  logic          w_sdram, w_act, w_rise, w_fall, w_wr_ok, w_odd, w_pv, w_match;
  logic          w_push, w_full, w_acc, w_pop, w_fin;
  logic [23:0]   w_push_a;
  logic [15:0]   w_push_d;
  logic [AW:0]   w_cnt_n;

  assign w_sdram  = |sdram_sz[2:0];
  assign w_act    = ioctl_download && (ioctl_index == OVR_INDEX);
  assign w_rise   = w_act & ~r_act_d;
  assign w_fall   = ~w_act & r_act_d;
  assign w_wr_ok  = w_sdram & w_act & ioctl_wr;
  assign w_odd    = ioctl_addr[0];
  // a pending byte from the previous load is forgotten on the start edge
  assign w_pv     = r_pend & ~w_rise;
  assign w_match  = w_pv && (r_paddr == ioctl_addr[24:1]);
  assign w_push   = w_wr_ok ? (w_odd | w_pv) : (w_fall & r_pend);
  assign w_push_a = (w_wr_ok & w_odd) ? ioctl_addr[24:1] : r_paddr;
  assign w_push_d = (w_wr_ok & w_odd) ? {ioctl_dout, w_match ? r_plow : 8'h00} : {8'h00, r_plow};
  assign w_full   = r_cnt == DEP;
  assign w_acc    = w_push & ~w_full;
  assign w_pop    = (r_st == IDLE) && (r_cnt != '0);
  assign w_cnt_n  = r_cnt + (AW+1)'(w_acc) - (AW+1)'(w_pop);
  assign w_fin    = r_load & ~w_act & (r_cnt == '0) & (r_st == IDLE) & ~r_pend;

  assign ioctl_wait = r_wait;
  assign mem_we     = r_we;
  assign mem_addr   = r_maddr;
  assign mem_din    = r_mdin;
  assign ovr_valid  = r_valid;
  assign ovr_words  = r_words;

  // pending low byte: captured on even strobes, consumed by odd strobes or the end of download
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_pend  <= 1'b0;
      r_plow  <= '0;
      r_paddr <= '0;
    end else if (w_wr_ok) begin
      r_pend <= ~w_odd;
      if (!w_odd) begin
        r_plow  <= ioctl_dout;
        r_paddr <= ioctl_addr[24:1];
      end
    end else if (w_rise | w_fall) r_pend <= 1'b0;

  // FIFO storage, no reset needed since occupancy guards every read
  always_ff @(posedge clk_sys)
    if (w_acc) begin
      r_fa[r_wp] <= w_push_a;
      r_fd[r_wp] <= w_push_d;
    end

  // FIFO pointers, occupancy and registered backpressure
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_wait <= 1'b0;
    end else begin
      r_wp   <= r_wp + AW'(w_acc);
      r_rp   <= r_rp + AW'(w_pop);
      r_cnt  <= w_cnt_n;
      r_wait <= w_cnt_n >= THR;
    end

  // write FSM: load head into the output registers on entry to ISSUE, hold them through WAIT
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_st    <= IDLE;
      r_we    <= 1'b0;
      r_maddr <= '0;
      r_mdin  <= '0;
    end else
      case (r_st)
        IDLE:
          if (w_pop) begin
            r_st    <= ISSUE;
            r_we    <= 1'b1;
            r_maddr <= {r_fa[r_rp], 1'b0};
            r_mdin  <= r_fd[r_rp];
          end
        ISSUE: begin
          r_st <= WAIT;
          r_we <= 1'b0;
        end
        default: if (mem_ready) r_st <= IDLE;
      endcase

  // load bookkeeping: restart on download start, validate once everything has drained
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_act_d <= 1'b0;
      r_load  <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_words <= '0;
    end else begin
      r_act_d <= w_act;
      if (w_rise) begin
        r_load  <= 1'b1;
        r_ovf   <= 1'b0;
        r_valid <= 1'b0;
        r_words <= '0;
      end else begin
        if (w_pop && r_words != '1) r_words <= r_words + 24'd1;
        if (w_push && w_full) r_ovf <= 1'b1;
        if (w_fin) begin
          r_load  <= 1'b0;
          r_valid <= w_sdram && (r_words != '0) && !r_ovf;
        end
      end
    end

`ifdef OVR_LOADER_CHECKSUM_EN
  logic [15:0] r_sum;
  assign ovr_sum = r_sum;
  // running sum of every word handed to the memory controller
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) r_sum <= '0;
    else if (w_rise) r_sum <= '0;
    else if (w_pop) r_sum <= r_sum + r_fd[r_rp];
`else
  assign ovr_sum = 16'h0000;
`endif
endmodule

// File: tb/tb_ovr_loader.sv
// tb_ovr_loader: randomized self-checking bench for ovr_loader against a byte-stream packing model.
module tb_ovr_loader;
  logic        clk_sys = 0, reset_n = 0, ioctl_download = 0, ioctl_wr = 0, mem_ready = 1;
  logic [7:0]  ioctl_index = 0, ioctl_dout = 0;
  logic [24:0] ioctl_addr = 0;
  logic [15:0] sdram_sz = 16'h0001;
  logic        ioctl_wait, mem_we, ovr_valid;
  logic [24:0] mem_addr;
  logic [15:0] mem_din, ovr_sum;
  logic [23:0] ovr_words;

  int checks = 0, errors = 0;
  int ready_mode = 0;
  int sent, sent_at_wait;
  bit wait_seen;
  logic [24:0] q_addr[$];
  logic [7:0]  q_data[$];
  logic [24:0] exp_a[$], got_a[$];
  logic [15:0] exp_d[$], got_d[$];

  ovr_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .sdram_sz(sdram_sz),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_ready(mem_ready),
    .ovr_valid(ovr_valid), .ovr_words(ovr_words), .ovr_sum(ovr_sum)
  );

  always #5 clk_sys = ~clk_sys;

  initial forever begin
    @(negedge clk_sys);
    mem_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  always @(negedge clk_sys) begin
    if (mem_we) begin
      got_a.push_back(mem_addr);
      got_d.push_back(mem_din);
    end
    if (ioctl_wait) wait_seen = 1;
  end

  // words the download should produce, derived from the byte stream in order
  task automatic build_expected();
    bit pv = 0;
    logic [23:0] pa = 0;
    logic [7:0] pl = 0;
    exp_a.delete(); exp_d.delete();
    foreach (q_addr[i]) begin
      if (!q_addr[i][0]) begin
        if (pv) begin exp_a.push_back({pa, 1'b0}); exp_d.push_back({8'h00, pl}); end
        pv = 1; pa = q_addr[i][24:1]; pl = q_data[i];
      end else begin
        exp_a.push_back({q_addr[i][24:1], 1'b0});
        exp_d.push_back({q_data[i], (pv && pa == q_addr[i][24:1]) ? pl : 8'h00});
        pv = 0;
      end
    end
    if (pv) begin exp_a.push_back({pa, 1'b0}); exp_d.push_back({8'h00, pl}); end
  endtask

  function automatic logic [15:0] exp_sum();
    logic [15:0] s = 0;
    foreach (exp_d[i]) s += exp_d[i];
`ifdef OVR_LOADER_CHECKSUM_EN
    return s;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int t = 0;
    while (ioctl_wait && t < 2000) begin
      if (sent_at_wait < 0) sent_at_wait = sent;
      @(negedge clk_sys); t++;
    end
    checks++;
    if (t >= 2000) begin errors++; $display("FAIL send_timeout: ioctl_wait stuck at %0b, required 0", ioctl_wait); end
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1; sent++;
    @(negedge clk_sys);
    ioctl_wr = 0;
    @(negedge clk_sys);
  endtask

  task automatic run_download(input logic [7:0] idx);
    int t = 0;
    got_a.delete(); got_d.delete();
    wait_seen = 0; sent = 0; sent_at_wait = -1;
    ioctl_index = idx; ioctl_download = 1;
    @(negedge clk_sys);
    foreach (q_addr[i]) send_byte(q_addr[i], q_data[i]);
    ioctl_download = 0;
    while (got_a.size() < exp_a.size() && t < 3000) begin @(negedge clk_sys); t++; end
    repeat (10) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL rst_we: got %0b want 0", mem_we); end
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL rst_wait: got %0b want 0", ioctl_wait); end
    checks++; if (ovr_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %0b want 0", ovr_valid); end
    checks++; if (mem_addr !== 25'd0)  begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    checks++; if (mem_din !== 16'd0)   begin errors++; $display("FAIL rst_din: got %h want 0", mem_din); end
    checks++; if (ovr_words !== 24'd0) begin errors++; $display("FAIL rst_words: got %0d want 0", ovr_words); end
    checks++; if (ovr_sum !== 16'd0)   begin errors++; $display("FAIL rst_sum: got %h want 0", ovr_sum); end
  endtask

  task automatic test_basic();
    logic [15:0] want_sum;
    ready_mode = 0;
    q_addr = '{0, 1, 2, 3}; q_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_a = '{25'd0, 25'd2}; exp_d = '{16'h2211, 16'h4433};
`ifdef OVR_LOADER_CHECKSUM_EN
    want_sum = 16'h6644;
`else
    want_sum = 16'h0000;
`endif
    run_download(8'd2);
    checks++; if (got_a.size() != 2) begin errors++; $display("FAIL basic_count: got %0d want 2", got_a.size()); end
    foreach (exp_a[i]) if (i < got_a.size()) begin
      checks++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL basic_word%0d: got %h@%h want %h@%h", i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
      end
    end
    checks++; if (ovr_words !== 24'd2) begin errors++; $display("FAIL basic_words: got %0d want 2", ovr_words); end
    checks++; if (ovr_valid !== 1'b1)  begin errors++; $display("FAIL basic_valid: got %0b want 1", ovr_valid); end
    checks++; if (ovr_sum !== want_sum) begin errors++; $display("FAIL basic_sum: got %h want %h", ovr_sum, want_sum); end
  endtask

  task automatic test_odd_tail();
    ready_mode = 0;
    q_addr = '{0, 1, 2}; q_data = '{8'hAA, 8'hBB, 8'hCC};
    exp_a = '{25'd0, 25'd2}; exp_d = '{16'hBBAA, 16'h00CC};
    run_download(8'd2);
    checks++; if (got_a.size() != 2) begin errors++; $display("FAIL tail_count: got %0d want 2", got_a.size()); end
    foreach (exp_a[i]) if (i < got_a.size()) begin
      checks++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL tail_word%0d: got %h@%h want %h@%h", i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
      end
    end
    checks++; if (ovr_valid !== 1'b1) begin errors++; $display("FAIL tail_valid: got %0b want 1", ovr_valid); end
  endtask

  task automatic test_random();
    ready_mode = 1;
    for (int r = 0; r < 6; r++) begin
      logic [24:0] a;
      int n;
      n = $urandom_range(1, 30);
      a = 25'($urandom_range(0, 1000));
      q_addr.delete(); q_data.delete();
      for (int k = 0; k < n; k++) begin
        q_addr.push_back(a); q_data.push_back(8'($urandom));
        a = ($urandom_range(0, 7) == 0) ? 25'($urandom_range(0, 2000)) : a + 25'd1;
      end
      build_expected();
      run_download(8'd2);
      checks++;
      if (got_a.size() != exp_a.size()) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", r, got_a.size(), exp_a.size()); end
      foreach (exp_a[i]) if (i < got_a.size()) begin
        checks++;
        if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
          errors++; $display("FAIL rand%0d_word%0d: got %h@%h want %h@%h", r, i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
        end
      end
      checks++; if (ovr_words !== 24'(exp_a.size())) begin errors++; $display("FAIL rand%0d_words: got %0d want %0d", r, ovr_words, exp_a.size()); end
      checks++; if (ovr_valid !== 1'b1) begin errors++; $display("FAIL rand%0d_valid: got %0b want 1", r, ovr_valid); end
      checks++; if (ovr_sum !== exp_sum()) begin errors++; $display("FAIL rand%0d_sum: got %h want %h", r, ovr_sum, exp_sum()); end
    end
    ready_mode = 0;
  endtask

  task automatic test_back_to_back();
    q_addr.delete(); q_data.delete();
    for (int k = 0; k < 20; k++) begin q_addr.push_back(25'(k)); q_data.push_back(8'($urandom)); end
    build_expected();
    ready_mode = 2;
    fork begin repeat (40) @(negedge clk_sys); ready_mode = 0; end join_none
    run_download(8'd2);
    checks++; if (!wait_seen) begin errors++; $display("FAIL bp_wait: ioctl_wait never 1, required 1"); end
    checks++; if (sent_at_wait != 8) begin errors++; $display("FAIL bp_wait_point: wait rose after %0d bytes, required 8", sent_at_wait); end
    checks++; if (got_a.size() != exp_a.size()) begin errors++; $display("FAIL bp_count: got %0d want %0d", got_a.size(), exp_a.size()); end
    foreach (exp_a[i]) if (i < got_a.size()) begin
      checks++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL bp_word%0d: got %h@%h want %h@%h", i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
      end
    end
    checks++; if (ovr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b want 1", ovr_valid); end
  endtask

  task automatic test_other_index();
    logic [23:0] w0;
    w0 = ovr_words;
    q_addr = '{0, 1, 2, 3}; q_data = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp_a.delete(); exp_d.delete();
    run_download(8'd1);
    checks++; if (got_a.size() != 0) begin errors++; $display("FAIL idx_writes: got %0d want 0", got_a.size()); end
    checks++; if (ovr_valid !== 1'b1) begin errors++; $display("FAIL idx_valid: got %0b want 1", ovr_valid); end
    checks++; if (ovr_words !== w0) begin errors++; $display("FAIL idx_words: got %0d want %0d", ovr_words, w0); end
  endtask

  task automatic test_no_sdram();
    sdram_sz = 16'hFFF8;
    q_addr.delete(); q_data.delete();
    for (int k = 0; k < 100; k++) begin q_addr.push_back(25'(k)); q_data.push_back(8'($urandom)); end
    exp_a.delete(); exp_d.delete();
    run_download(8'd2);
    checks++; if (got_a.size() != 0) begin errors++; $display("FAIL nosd_writes: got %0d want 0", got_a.size()); end
    checks++; if (ovr_valid !== 1'b0) begin errors++; $display("FAIL nosd_valid: got %0b want 0", ovr_valid); end
    checks++; if (wait_seen) begin errors++; $display("FAIL nosd_wait: ioctl_wait seen 1, required 0"); end
    sdram_sz = 16'h0001;
  endtask

  task automatic test_reset_mid_write();
    int t = 0;
    ready_mode = 2;
    got_a.delete(); got_d.delete();
    ioctl_index = 8'd2; ioctl_download = 1;
    @(negedge clk_sys);
    send_byte(25'd0, 8'h5A);
    send_byte(25'd1, 8'hA5);
    while (got_a.size() < 1 && t < 100) begin @(negedge clk_sys); t++; end
    checks++; if (got_a.size() != 1) begin errors++; $display("FAIL mid_issue: got %0d writes want 1", got_a.size()); end
    repeat (2) @(negedge clk_sys);
    #2 reset_n = 0; ioctl_download = 0;
    #1;
    checks++;
    if ({mem_we, ioctl_wait, ovr_valid} !== 3'b000 || mem_addr !== 25'd0 || mem_din !== 16'd0 || ovr_words !== 24'd0 || ovr_sum !== 16'd0) begin
      errors++; $display("FAIL mid_async: we=%0b wait=%0b valid=%0b addr=%h din=%h words=%0d sum=%h, required all 0",
                          mem_we, ioctl_wait, ovr_valid, mem_addr, mem_din, ovr_words, ovr_sum);
    end
    repeat (3) @(negedge clk_sys);
    reset_n = 1; ready_mode = 0;
    got_a.delete(); got_d.delete();
    repeat (20) @(negedge clk_sys);
    checks++; if (got_a.size() != 0) begin errors++; $display("FAIL mid_after: got %0d writes want 0", got_a.size()); end
  endtask

  initial begin
    repeat (3) @(negedge clk_sys);
    test_reset();
    reset_n = 1;
    repeat (2) @(negedge clk_sys);
    test_reset();
    test_basic();
    test_odd_tail();
    test_random();
    test_other_index();
    test_back_to_back();
    test_no_sdram();
    test_reset_mid_write();
    test_basic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
